// File: rtl/minterm_pkg.sv
// Shared types and constants for the minterm sweep controller.
// Holds the FSM state encoding and the default sweep geometry.
package minterm_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_DONE
    } state_e;

    localparam int N_IN_DEF = 3;
    localparam int N_VEC    = 1 << N_IN_DEF;
    localparam int WAIT_W   = 4;

endpackage

// File: rtl/minterm_sweep_ctrl_if.sv
// Handshake and result bundle between the sweep controller and its user.
// The master drives start/abort and the implementation outputs.
interface minterm_sweep_ctrl_if
    import minterm_pkg::*;
#(
    parameter int N_IN = N_IN_DEF
);

    logic                   start;
    logic                   abort;
    logic                   y_a;
    logic                   y_b;
    logic [N_IN-1:0]        stim;
    logic                   busy;
    logic                   done;
    logic                   pass;
    logic [N_IN:0]          mismatch_cnt;
    logic [(1<<N_IN)-1:0]   fail_map;
    logic                   first_fail_valid;
    logic [N_IN-1:0]        first_fail_vec;

    modport master (
        output start, abort, y_a, y_b,
        input  stim, busy, done, pass,
        input  mismatch_cnt, fail_map,
        input  first_fail_valid, first_fail_vec
    );

    modport slave (
        input  start, abort, y_a, y_b,
        output stim, busy, done, pass,
        output mismatch_cnt, fail_map,
        output first_fail_valid, first_fail_vec
    );

endinterface

// File: rtl/minterm_result_tracker.sv
// Mismatch bookkeeping: count, per-vector fail map, first failing vector.
// Cleared on sweep start, updated on each sampling strobe.
module minterm_result_tracker
    import minterm_pkg::*;
#(
    parameter int N_IN = N_IN_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr_i,
    input  logic                 rec_i,
    input  logic                 miss_i,
    input  logic [N_IN-1:0]      vec_i,
    output logic [N_IN:0]        cnt_o,
    output logic [(1<<N_IN)-1:0] map_o,
    output logic                 ff_valid_o,
    output logic [N_IN-1:0]      ff_vec_o
);

    logic [N_IN:0]        cnt_q, cnt_d;
    logic [(1<<N_IN)-1:0] map_q, map_d;
    logic                 ffv_q, ffv_d;
    logic [N_IN-1:0]      ffvec_q, ffvec_d;

    // Next-state of the result registers: clear wins over record.
    always_comb begin
        cnt_d   = cnt_q;
        map_d   = map_q;
        ffv_d   = ffv_q;
        ffvec_d = ffvec_q;
        if (clr_i) begin
            cnt_d   = '0;
            map_d   = '0;
            ffv_d   = 1'b0;
            ffvec_d = '0;
        end else if (rec_i && miss_i) begin
            cnt_d        = cnt_q + (N_IN+1)'(1);
            map_d[vec_i] = 1'b1;
            if (!ffv_q) begin
                ffv_d   = 1'b1;
                ffvec_d = vec_i;
            end
        end
    end

    // Result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            map_q   <= '0;
            ffv_q   <= 1'b0;
            ffvec_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            map_q   <= map_d;
            ffv_q   <= ffv_d;
            ffvec_q <= ffvec_d;
        end
    end

    assign cnt_o      = cnt_q;
    assign map_o      = map_q;
    assign ff_valid_o = ffv_q;
    assign ff_vec_o   = ffvec_q;

endmodule

// File: rtl/minterm_sweep_ctrl.sv
// Sweep controller: walks every input vector, holds it SETTLE cycles,
// then compares the two implementation outputs and logs mismatches.
module minterm_sweep_ctrl
    import minterm_pkg::*;
#(
    parameter int N_IN   = N_IN_DEF,
    parameter int SETTLE = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    minterm_sweep_ctrl_if.slave  bus
);

    localparam int NV = (N_IN == N_IN_DEF) ? N_VEC : (1 << N_IN);
    localparam logic [N_IN-1:0]   LAST   = N_IN'(NV - 1);
    localparam logic [WAIT_W-1:0] W_LAST = WAIT_W'(SETTLE - 1);

    state_e              state_q, state_d;
    logic [N_IN-1:0]     stim_q, stim_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic                clr, rec;
    logic                sample, last_vec, go;
    logic [N_IN:0]       cnt;
    logic [(1<<N_IN)-1:0] map;
    logic                ffv;
    logic [N_IN-1:0]     ffvec;

    assign sample   = (state_q == S_SETTLE) && (wait_q == W_LAST);
    assign last_vec = (stim_q == LAST);
    assign go       = bus.start && !bus.abort;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state: abort beats start and beats the final sample.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (go) state_d = S_SETTLE;
            S_SETTLE: begin
                if (bus.abort)
                    state_d = S_IDLE;
                else if (sample && last_vec)
                    state_d = S_DONE;
            end
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Output/datapath control derived from the current state.
    always_comb begin
        clr    = 1'b0;
        rec    = 1'b0;
        stim_d = stim_q;
        wait_d = wait_q;
        busy_d = busy_q;
        done_d = 1'b0;
        pass_d = pass_q;
        unique case (state_q)
            S_IDLE: begin
                if (go) begin
                    clr    = 1'b1;
                    stim_d = '0;
                    wait_d = '0;
                    busy_d = 1'b1;
                    pass_d = 1'b0;
                end
            end
            S_SETTLE: begin
                if (bus.abort) begin
                    busy_d = 1'b0;
                    pass_d = 1'b0;
                end else if (sample) begin
                    rec = 1'b1;
                    if (!last_vec) begin
                        stim_d = stim_q + N_IN'(1);
                        wait_d = '0;
                    end
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_DONE: begin
                done_d = 1'b1;
                busy_d = 1'b0;
                pass_d = (cnt == '0);
            end
            default: ;
        endcase
    end

    // Stimulus, settle counter and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stim_q <= '0;
            wait_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            pass_q <= 1'b0;
        end else begin
            stim_q <= stim_d;
            wait_q <= wait_d;
            busy_q <= busy_d;
            done_q <= done_d;
            pass_q <= pass_d;
        end
    end

    minterm_result_tracker #(
        .N_IN (N_IN)
    ) u_trk (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (clr),
        .rec_i      (rec),
        .miss_i     (bus.y_a != bus.y_b),
        .vec_i      (stim_q),
        .cnt_o      (cnt),
        .map_o      (map),
        .ff_valid_o (ffv),
        .ff_vec_o   (ffvec)
    );

    assign bus.stim             = stim_q;
    assign bus.busy             = busy_q;
    assign bus.done             = done_q;
    assign bus.pass             = pass_q;
    assign bus.mismatch_cnt     = cnt;
    assign bus.fail_map         = map;
    assign bus.first_fail_valid = ffv;
    assign bus.first_fail_vec   = ffvec;

endmodule
